minicpu_multicycle: RTL
=======================

MINICPU_MULTICYCLE -- requirements
Module: minicpu_multicycle

Interface
REQ-001 Parameter: RESET_PC, 32'h1c000000, address of the first fetch after reset.
REQ-002 Parameter: CNT_W, 32, width of the retired-instruction counter.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: resetn  in  1  asynchronous, active-low reset.
REQ-005 Ports: inst_req out 1, inst_addr out 32, inst_addr_ok in 1, inst_data_ok in 1, inst_rdata in 32; read-only fetch channel.
REQ-006 Ports: data_req out 1, data_we out 1, data_addr out 32, data_wdata out 32, data_addr_ok in 1, data_data_ok in 1, data_rdata in 32; load/store channel.
REQ-007 Ports: debug_wb_pc out 32, debug_wb_rf_we out 1, debug_wb_rf_wnum out 5, debug_wb_rf_wdata out 32; retire trace.
REQ-008 Ports: halted out 1 (invalid-instruction stop), retired_cnt out CNT_W (instructions retired).

Function
REQ-009 FSM states: IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
REQ-010 IF_REQ: inst_req=1, inst_addr=pc; request accepted in the cycle where inst_addr_ok=1, after which the FSM goes to IF_WAIT; inst_req and inst_addr are held stable until acceptance.
REQ-011 IF_WAIT: inst_req=0; on inst_data_ok=1, latch inst_rdata into IR, then go to EXEC. At most one request is outstanding per channel.
REQ-012 Decoded instructions: add.w, sub.w, addi.w, ld.w, st.w, beq, bne, b, bl. All other encodings go to HALT.
REQ-013 Encodings: add.w IR[31:15]=17'h00020; sub.w 17'h00022; addi.w IR[31:22]=10'h00a; ld.w 10'h0a2; st.w 10'h0a6; beq IR[31:26]=6'h16; bne 6'h17; b 6'h14; bl 6'h15.
REQ-014 Operand fields: rd=IR[4:0], rj=IR[9:5], rk=IR[14:10]. si12 is sign-extended. Branch offset is sext(IR[25:10])<<2. b/bl offset is sext({IR[9:0],IR[25:10]})<<2.
REQ-015 EXEC: read rj and (rk, or rd for st.w/beq/bne), compute the 32-bit ALU result modulo 2^32, resolve branches, compute next_pc. Then go to MEM_REQ for ld.w/st.w, HALT for invalid encodings, and WB otherwise.
REQ-016 MEM_REQ: data_req=1, data_addr=rj+si12, data_we=1 only for st.w, data_wdata=value of rd. On data_addr_ok, go to MEM_WAIT.
REQ-017 MEM_WAIT: on data_data_ok, latch data_rdata (for ld.w) and go to WB. Store completion is also signalled by data_data_ok.
REQ-018 WB, one cycle: write the regfile if gr_we, update pc<=next_pc, increment retired_cnt, then go to IF_REQ.
REQ-019 gr_we is set for add.w, sub.w, addi.w, ld.w (destination rd) and bl (destination r1, value pc+4). Writes to r0 are discarded; r0 always reads 0.
REQ-020 Branch rules: beq is taken if rj==rd; bne is taken if rj!=rd; b and bl are always taken. A taken branch sets next_pc=pc+offset; otherwise next_pc=pc+4.
REQ-021 Debug trace: debug_wb_rf_we=1 only in WB with gr_we and a nonzero destination; it is 0 in all other cycles. debug_wb_pc is the pc of the retiring instruction.
REQ-022 Minimum latency with addr_ok asserted in the request cycle and data_ok on the next cycle: 4 cycles for ALU/branch instructions and 6 cycles for ld.w/st.w.
REQ-023 HALT is absorbing: halted=1, no requests are issued, and only reset exits HALT.
REQ-024 retired_cnt wraps from 2^CNT_W-1 to 0.
REQ-025 Handshake strobes (addr_ok, data_ok) arriving in any state other than the one waiting for them are ignored.

Reset
REQ-026 While resetn=0: pc=RESET_PC, state=IF_REQ, retired_cnt=0, halted=0, IR=0, and all req/we/debug outputs are 0.
REQ-027 The first inst_req is asserted in the first cycle after resetn deasserts. Asserting reset mid-transaction abandons that transaction. Memories share resetn, so no stale data_ok arrives after reset.
REQ-028 Regfile contents are not reset, except that r0 is hardwired to 0.

Structure
REQ-029 Shared package minicpu_pkg holds the FSM state enum, the opcode constants of REQ-013, and RESET_PC_DEFAULT.
REQ-030 The sub-module mc_regfile provides 32x32 storage with two asynchronous read ports and one synchronous write port. Everything else is inline.

Verification
REQ-031 Reset, then zero-wait memory, then addi.w r1,r0,5 and add.w r2,r1,r1: trace shows r1=5 and r2=10, the second WB occurs 4 cycles after the first, and retired_cnt=2.
REQ-032 st.w r2,r0,0x10 then ld.w r3,r0,0x10 with data_addr_ok delayed by 3 cycles: data_addr stays 0x10 and data_req stays high until accepted; trace shows r3=10.
REQ-033 bne r1,r2,+8 with r1≠r2: next inst_addr=pc+8. beq with equal operands: next inst_addr=pc+offset. Not-taken case: next inst_addr=pc+4.
REQ-034 bl +0x100 at pc 0x1c000020: r1=0x1c000024 and the next fetch is 0x1c000120. addi.w r0,r0,7: debug_wb_rf_we=0 and r0 still reads 0.
REQ-035 Fetch of 0xffffffff: halted=1 and no further inst_req. Spurious inst_data_ok pulses in HALT are ignored. resetn low, then high: fetch restarts at RESET_PC.
REQ-036 resetn asserted while in MEM_WAIT: data_req drops immediately, retired_cnt=0, and the first post-reset request goes to RESET_PC.

Source files
------------

// File: rtl/minicpu_pkg.sv
// Shared definitions for the multicycle mini CPU: FSM states, opcode fields
// and the default boot address.
package minicpu_pkg;

    typedef enum logic [2:0] {
        IF_REQ,
        IF_WAIT,
        EXEC,
        MEM_REQ,
        MEM_WAIT,
        WB,
        HALT
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

    // Major opcode fields; each is compared against a different slice of IR
    localparam logic [16:0] OP_ADD_W  = 17'h00020;
    localparam logic [16:0] OP_SUB_W  = 17'h00022;
    localparam logic [9:0]  OP_ADDI_W = 10'h00a;
    localparam logic [9:0]  OP_LD_W   = 10'h0a2;
    localparam logic [9:0]  OP_ST_W   = 10'h0a6;
    localparam logic [5:0]  OP_BEQ    = 6'h16;
    localparam logic [5:0]  OP_BNE    = 6'h17;
    localparam logic [5:0]  OP_B      = 6'h14;
    localparam logic [5:0]  OP_BL     = 6'h15;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 general register file: two asynchronous read ports, one synchronous
// write port, r0 hardwired to zero.
module mc_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] regs [0:31];

    // Contents are deliberately not reset; entry 0 is never written
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/minicpu_multicycle.sv
// Multicycle mini CPU with request/ack fetch and load/store channels,
// a retire trace port and a sticky halt on undecodable instructions.
module minicpu_multicycle
    import minicpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,

    output logic             inst_req,
    output logic [31:0]      inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [31:0]      inst_rdata,

    output logic             data_req,
    output logic             data_we,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    input  logic [31:0]      data_rdata,

    output logic [31:0]      debug_wb_pc,
    output logic             debug_wb_rf_we,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata,

    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t state, next_state;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] res_q;
    logic [31:0] next_pc_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [4:0]  dest_q;
    logic        gr_we_q;
    logic        is_store_q;

    logic [4:0]  rd, rj, rk, raddr2;
    logic        op_add, op_sub, op_addi, op_ld, op_st;
    logic        op_beq, op_bne, op_b, op_bl, is_valid;
    logic [31:0] rj_val, r2_val;
    logic [31:0] si12, off16, off26;
    logic [31:0] alu_res, exec_next_pc;
    logic        taken, exec_gr_we, rf_we;
    logic [4:0]  exec_dest;

    assign rd = ir[4:0];
    assign rj = ir[9:5];
    assign rk = ir[14:10];

    assign op_add  = (ir[31:15] == OP_ADD_W);
    assign op_sub  = (ir[31:15] == OP_SUB_W);
    assign op_addi = (ir[31:22] == OP_ADDI_W);
    assign op_ld   = (ir[31:22] == OP_LD_W);
    assign op_st   = (ir[31:22] == OP_ST_W);
    assign op_beq  = (ir[31:26] == OP_BEQ);
    assign op_bne  = (ir[31:26] == OP_BNE);
    assign op_b    = (ir[31:26] == OP_B);
    assign op_bl   = (ir[31:26] == OP_BL);
    assign is_valid = op_add | op_sub | op_addi | op_ld | op_st
                    | op_beq | op_bne | op_b | op_bl;

    // Stores and conditional branches read rd on the second port instead of rk
    assign raddr2 = (op_st | op_beq | op_bne) ? rd : rk;

    assign si12  = sext12(ir[21:10]);
    assign off16 = {{14{ir[25]}}, ir[25:10], 2'b00};
    assign off26 = {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00};

    mc_regfile u_regfile (
        .clk    (clk),
        .we     (rf_we),
        .waddr  (dest_q),
        .wdata  (res_q),
        .raddr1 (rj),
        .rdata1 (rj_val),
        .raddr2 (raddr2),
        .rdata2 (r2_val)
    );

    always_comb begin
        alu_res = 32'd0;
        if (op_add) begin
            alu_res = rj_val + r2_val;
        end else if (op_sub) begin
            alu_res = rj_val - r2_val;
        end else if (op_addi | op_ld | op_st) begin
            alu_res = rj_val + si12;
        end else if (op_bl) begin
            alu_res = pc + 32'd4;
        end
    end

    assign taken = (op_beq & (rj_val == r2_val)) | (op_bne & (rj_val != r2_val))
                 | op_b | op_bl;
    assign exec_next_pc = taken ? (pc + ((op_b | op_bl) ? off26 : off16))
                                : (pc + 32'd4);
    assign exec_gr_we = op_add | op_sub | op_addi | op_ld | op_bl;
    assign exec_dest  = op_bl ? 5'd1 : rd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IF_REQ;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IF_REQ:   if (inst_addr_ok) next_state = IF_WAIT;
            IF_WAIT:  if (inst_data_ok) next_state = EXEC;
            EXEC: begin
                if (!is_valid) begin
                    next_state = HALT;
                end else if (op_ld | op_st) begin
                    next_state = MEM_REQ;
                end else begin
                    next_state = WB;
                end
            end
            MEM_REQ:  if (data_addr_ok) next_state = MEM_WAIT;
            MEM_WAIT: if (data_data_ok) next_state = WB;
            WB:       next_state = IF_REQ;
            HALT:     next_state = HALT;
            default:  next_state = HALT;
        endcase
    end

    // Operands and results are captured in EXEC so the memory request stays
    // stable for however long the slave takes to accept it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc          <= RESET_PC;
            ir          <= 32'd0;
            res_q       <= 32'd0;
            next_pc_q   <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            dest_q      <= 5'd0;
            gr_we_q     <= 1'b0;
            is_store_q  <= 1'b0;
            retired_cnt <= '0;
        end else begin
            case (state)
                IF_WAIT: begin
                    if (inst_data_ok) ir <= inst_rdata;
                end
                EXEC: begin
                    res_q       <= alu_res;
                    next_pc_q   <= exec_next_pc;
                    mem_addr_q  <= rj_val + si12;
                    mem_wdata_q <= r2_val;
                    dest_q      <= exec_dest;
                    gr_we_q     <= exec_gr_we;
                    is_store_q  <= op_st;
                end
                MEM_WAIT: begin
                    if (data_data_ok && !is_store_q) res_q <= data_rdata;
                end
                WB: begin
                    pc          <= next_pc_q;
                    retired_cnt <= retired_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rf_we = (state == WB) && gr_we_q;

    // Fetch request is masked by reset so it first appears once reset lifts
    assign inst_req   = (state == IF_REQ) && resetn;
    assign inst_addr  = pc;
    assign data_req   = (state == MEM_REQ);
    assign data_we    = (state == MEM_REQ) && is_store_q;
    assign data_addr  = mem_addr_q;
    assign data_wdata = mem_wdata_q;

    assign debug_wb_pc       = (state == WB) ? pc : 32'd0;
    assign debug_wb_rf_we    = rf_we && (dest_q != 5'd0);
    assign debug_wb_rf_wnum  = (state == WB) ? dest_q : 5'd0;
    assign debug_wb_rf_wdata = (state == WB) ? res_q : 32'd0;

    assign halted = (state == HALT);

endmodule
